// File: rtl/alsu_pipe.sv
// alsu_pipe: handshaked ALSU with capture stage and sequential multiplier.
// Ports: clk, rst (async, active-low), in_valid/in_ready, A, B, cin,
//   serial_in, direction, red_op_A/B, bypass_A/B, opcode -> out (2*WIDTH),
//   out_valid (1-cycle pulse), invalid (sticky), leds (blink while invalid).
module alsu_pipe #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic [2:0]           opcode,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 invalid,
    output logic [15:0]          leds
);
    localparam int  W2     = 2 * WIDTH;
    localparam int  CW     = $clog2(WIDTH + 1);
    localparam int  BW     = $clog2(BLINK_DIV + 1);
    localparam bit  PRIO_A = (INPUT_PRIORITY == "A");
    localparam bit  FA_ON  = (FULL_ADDER == "ON");

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q;
    logic [W2-1:0]     out_q, acc_q, mcand_q, acc_d, res_d;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     blink_q;
    logic              out_valid_q, invalid_q, ill_d;
    logic [15:0]       leds_q;

    // captured command, executed on the edge after accept
    logic              c_vld_q, c_cin_q, c_sin_q, c_dir_q;
    logic              c_ra_q, c_rb_q, c_ba_q, c_bb_q;
    logic [WIDTH-1:0]  c_a_q, c_b_q;
    logic [2:0]        c_op_q;

    logic              accept, mul_in;
    logic [WIDTH-1:0]  red_src, byp_src;
    logic [W2-1:0]     a_ext, b_ext, cin_ext;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    // MUL only runs on the FSM when nothing overrides or rejects it
    assign mul_in    = (opcode == 3'd3) && !bypass_A && !bypass_B
                     && !red_op_A && !red_op_B;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign invalid   = invalid_q;
    assign leds      = leds_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld_q <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_cin_q <= 1'b0;
            c_sin_q <= 1'b0;
            c_dir_q <= 1'b0;
            c_ra_q  <= 1'b0;
            c_rb_q  <= 1'b0;
            c_ba_q  <= 1'b0;
            c_bb_q  <= 1'b0;
            c_op_q  <= '0;
        end else begin
            c_vld_q <= accept && !mul_in;
            if (accept) begin
                c_a_q   <= A;
                c_b_q   <= B;
                c_cin_q <= cin;
                c_sin_q <= serial_in;
                c_dir_q <= direction;
                c_ra_q  <= red_op_A;
                c_rb_q  <= red_op_B;
                c_ba_q  <= bypass_A;
                c_bb_q  <= bypass_B;
                c_op_q  <= opcode;
            end
        end
    end

    always_comb begin
        res_d   = '0;
        ill_d   = 1'b0;
        a_ext   = {{WIDTH{1'b0}}, c_a_q};
        b_ext   = {{WIDTH{1'b0}}, c_b_q};
        cin_ext = {{(W2-1){1'b0}}, c_cin_q & FA_ON};
        red_src = (c_ra_q && (!c_rb_q || PRIO_A)) ? c_a_q : c_b_q;
        byp_src = (c_ba_q && (!c_bb_q || PRIO_A)) ? c_a_q : c_b_q;
        if (c_ba_q || c_bb_q) begin
            res_d = {{WIDTH{1'b0}}, byp_src};
        end else if (c_op_q[2:1] == 2'b11) begin
            ill_d = 1'b1;
        end else if ((c_ra_q || c_rb_q) && c_op_q > 3'd1) begin
            ill_d = 1'b1;
        end else begin
            case (c_op_q)
                3'd0: res_d = (c_ra_q || c_rb_q)
                            ? {{(W2-1){1'b0}}, &red_src}
                            : a_ext & b_ext;
                3'd1: res_d = (c_ra_q || c_rb_q)
                            ? {{(W2-1){1'b0}}, ^red_src}
                            : a_ext ^ b_ext;
                3'd2: res_d = a_ext + b_ext + cin_ext;
                3'd4: res_d = c_dir_q
                            ? {out_q[W2-2:0], c_sin_q}
                            : {c_sin_q, out_q[W2-1:1]};
                3'd5: res_d = c_dir_q
                            ? {out_q[W2-2:0], out_q[W2-1]}
                            : {out_q[0], out_q[W2-1:1]};
                default: res_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
            leds_q      <= '0;
            blink_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                blink_q <= '0;
            end else if (invalid_q) begin
                if (blink_q == BW'(BLINK_DIV - 1)) begin
                    blink_q <= '0;
                    leds_q  <= ~leds_q;
                end else begin
                    blink_q <= blink_q + 1'b1;
                end
            end
            if (accept && mul_in) begin
                state_q  <= BUSY;
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, A};
                mplier_q <= B;
                cnt_q    <= '0;
            end
            if (state_q == BUSY) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_q     <= IDLE;
                    out_q       <= acc_d;
                    out_valid_q <= 1'b1;
                    invalid_q   <= 1'b0;
                    leds_q      <= '0;
                end
            end
            // a capture-stage result never coincides with a MUL finish
            if (c_vld_q) begin
                out_q       <= res_d;
                out_valid_q <= 1'b1;
                invalid_q   <= ill_d;
                leds_q      <= ill_d ? 16'hFFFF : 16'h0000;
                if (ill_d) blink_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed vector table plus multi-cycle sequences
// (back-to-back, MUL busy window, blink pattern, reset mid-MUL).
module tb_alsu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ready_off;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, direction;
    logic        red_op_A, red_op_B, bypass_A, bypass_B;
    logic [5:0]  out, out_off;
    logic        out_valid, out_valid_off;
    logic        invalid, invalid_off;
    logic [15:0] leds, leds_off;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alsu_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode),
        .out(out), .out_valid(out_valid), .invalid(invalid), .leds(leds)
    );

    alsu_pipe #(.FULL_ADDER("OFF")) u_off (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_off),
        .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode),
        .out(out_off), .out_valid(out_valid_off), .invalid(invalid_off),
        .leds(leds_off)
    );

    typedef struct {
        logic [2:0] op, a, b;
        logic       cin, sin, dir, ra, rb, ba, bb;
        logic [5:0] exp, exp_off;
        logic       inv;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(
        input logic [2:0] op, a, b,
        input logic cin, sin, dir, ra, rb, ba, bb,
        input logic [5:0] exp, exp_off,
        input logic inv);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.cin = cin; v.sin = sin; v.dir = dir;
        v.ra = ra; v.rb = rb; v.ba = ba; v.bb = bb;
        v.exp = exp; v.exp_off = exp_off; v.inv = inv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op; A = v.a; B = v.b;
        cin = v.cin; serial_in = v.sin; direction = v.dir;
        red_op_A = v.ra; red_op_B = v.rb;
        bypass_A = v.ba; bypass_B = v.bb;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic c);
        drive(mk(op, a, b, c, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        //          op a  b  ci si di ra rb ba bb exp off inv
        vt[0]  = mk(0, 6, 3, 0, 0, 0, 0, 0, 0, 0, 2,  2,  0);
        vt[1]  = mk(1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 6,  6,  0);
        vt[2]  = mk(2, 7, 7, 1, 0, 0, 0, 0, 0, 0, 15, 14, 0);
        vt[3]  = mk(2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 7,  7,  0);
        vt[4]  = mk(0, 7, 3, 0, 0, 0, 1, 1, 0, 0, 1,  1,  0);
        vt[5]  = mk(1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0,  0,  0);
        vt[6]  = mk(1, 3, 7, 0, 0, 0, 0, 1, 0, 0, 1,  1,  0);
        vt[7]  = mk(2, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0,  0,  1);
        vt[8]  = mk(7, 2, 5, 0, 0, 0, 0, 0, 1, 1, 2,  2,  0);
        vt[9]  = mk(3, 1, 6, 0, 0, 0, 0, 0, 0, 1, 6,  6,  0);
        vt[10] = mk(0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 5,  5,  0);
        vt[11] = mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 11, 11, 0);
        vt[12] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 37, 37, 0);
        vt[13] = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 18, 18, 0);
        vt[14] = mk(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 36, 36, 0);
        vt[15] = mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 50, 50, 0);
        vt[16] = mk(6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  1);

        rst = 1'b0;
        in_valid = 1'b0;
        cmd(0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_invalid", invalid, 0);
        chk("rst_leds", leds, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            chk($sformatf("v%0d_out", i), out, vt[i].exp);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_invalid", i), invalid, vt[i].inv);
            chk($sformatf("v%0d_out_off", i), out_off, vt[i].exp_off);
        end

        // illegal opcode: blink FFFF x4, 0000 x4, FFFF x4
        cmd(6, 0, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("blink%0d", i), leds,
                (((i - 1) / 4) % 2 == 0) ? 16'hFFFF : 16'h0000);
            if (i == 1) begin
                chk("ill_out", out, 0);
                chk("ill_invalid", invalid, 1);
            end
        end
        cmd(0, 6, 3, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("and_after_ill_out", out, 2);
        chk("and_after_ill_inv", invalid, 0);
        chk("and_after_ill_leds", leds, 0);
        step();
        chk("leds_stay_off", leds, 0);

        // back-to-back ADDs
        cmd(2, 1, 2, 0);
        in_valid = 1'b1;
        step();
        cmd(2, 2, 2, 0);
        step();
        chk("b2b_out0", out, 3);
        chk("b2b_val0", out_valid, 1);
        cmd(2, 3, 3, 0);
        step();
        chk("b2b_out1", out, 4);
        chk("b2b_val1", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("b2b_out2", out, 6);
        chk("b2b_val2", out_valid, 1);
        step();
        chk("b2b_val_end", out_valid, 0);

        // MUL 7*6 with a held command waiting on in_ready
        cmd(3, 7, 6, 0);
        in_valid = 1'b1;
        step();
        cmd(2, 1, 1, 0);
        chk("mul_ready_k", in_ready, 0);
        chk("mul_val_k", out_valid, 0);
        for (int i = 1; i <= 2; i++) begin
            step();
            chk($sformatf("mul_ready_k%0d", i), in_ready, 0);
            chk($sformatf("mul_val_k%0d", i), out_valid, 0);
            chk($sformatf("mul_hold_k%0d", i), out, 6);
        end
        step();
        chk("mul_out", out, 42);
        chk("mul_val", out_valid, 1);
        chk("mul_ready_done", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("held_val_accept", out_valid, 0);
        step();
        chk("held_out", out, 2);
        chk("held_val", out_valid, 1);

        // reset in the middle of MUL 5*5
        cmd(3, 5, 5, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_out", out, 0);
        chk("mrst_leds", leds, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_val", out_valid, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("mrst_noval%0d", i), out_valid, 0);
            chk($sformatf("mrst_out%0d", i), out, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
